// File: rtl/envelope_sequencer_if.sv
// Host write port and sample_counter configuration bus of the envelope sequencer.
interface envelope_sequencer_if;
  logic [15:0] host_data_in;
  logic [5:0]  host_addr_in;
  logic        host_valid_in;
  logic        host_ready_out;
  logic [15:0] data_out;
  logic [5:0]  addr_out;
  logic        data_valid_out;
  logic        busy_out;
  logic        overrun_out;

  modport master (
    output host_data_in, host_addr_in, host_valid_in,
    input  host_ready_out, data_out, addr_out, data_valid_out, busy_out, overrun_out
  );

  modport slave (
    input  host_data_in, host_addr_in, host_valid_in,
    output host_ready_out, data_out, addr_out, data_valid_out, busy_out, overrun_out
  );
endinterface

// File: rtl/envelope_sequencer.sv
// Per-frame linear attack/release envelope for 4 voices, merged round-robin with host writes onto one bus.
// Granted writes appear one cycle after grant; host is held off only while the envelope is owed its turn.
module envelope_sequencer #(
  parameter int          NUM_VOICES = 4,
  parameter logic [5:0]  VOL_BASE   = 6'h04,
  parameter logic [9:0]  TICK_COUNT = 10'h3FF
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic [9:0] master_count_in,
  envelope_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, REQ, NEXT} state_t;

  state_t      state_q, state_d;
  logic [1:0]  v_q, v_d;
  logic        tick_pending_q, tick_pending_d;
  logic        overrun_q, overrun_d;
  logic        last_host_q;

  logic [NUM_VOICES-1:0] gate_q, en_q;
  logic [7:0] step_q   [NUM_VOICES];
  logic [7:0] target_q [NUM_VOICES];
  logic [7:0] level_q  [NUM_VOICES];

  logic [15:0] data_q;
  logic [5:0]  addr_q;
  logic        dvld_q;

  logic tick, busy, env_req, host_ready, host_fwd, host_grant, env_grant, cfg_wr, tick_take;
  logic [1:0] cfg_idx;
  logic [7:0] cur_level, cur_step, cur_target, new_level;
  logic [8:0] sum9;

  assign tick       = (master_count_in == TICK_COUNT);
  assign busy       = (state_q != IDLE);
  assign env_req    = (state_q == REQ);
  // Host loses only when both could go and it had the previous grant.
  assign host_ready = !(env_req && last_host_q);
  assign host_fwd   = bus.host_valid_in && !bus.host_addr_in[5];
  assign host_grant = host_fwd && host_ready;
  assign env_grant  = env_req && !host_grant;
  assign cfg_wr     = bus.host_valid_in && host_ready && (bus.host_addr_in[5:3] == 3'b100);
  assign cfg_idx    = bus.host_addr_in[1:0];

  assign cur_level  = level_q[v_q];
  assign cur_step   = step_q[v_q];
  assign cur_target = target_q[v_q];
  assign sum9       = {1'b0, cur_level} + {1'b0, cur_step};

  always_comb begin
    new_level = cur_level;
    if (gate_q[v_q]) begin
      if (sum9[8] || (sum9[7:0] > cur_target)) new_level = cur_target;
      else                                     new_level = sum9[7:0];
    end else begin
      new_level = (cur_level > cur_step) ? (cur_level - cur_step) : 8'h00;
    end
  end

  always_comb begin
    state_d   = state_q;
    v_d       = v_q;
    tick_take = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick_pending_q) begin
          tick_take = 1'b1;
          v_d       = 2'd0;
          state_d   = CALC;
        end
      end
      CALC: state_d = en_q[v_q] ? REQ : NEXT;
      REQ:  if (env_grant) state_d = NEXT;
      NEXT: begin
        if (v_q == 2'(NUM_VOICES - 1)) begin
          state_d = IDLE;
        end else begin
          v_d     = v_q + 2'd1;
          state_d = CALC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tick_pending_d = (tick_pending_q && !tick_take) || (tick && !tick_pending_q && !busy);
    overrun_d      = overrun_q || (tick && (tick_pending_q || busy));
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q        <= IDLE;
      v_q            <= 2'd0;
      tick_pending_q <= 1'b0;
      overrun_q      <= 1'b0;
      last_host_q    <= 1'b0;
      data_q         <= 16'h0000;
      addr_q         <= 6'h00;
      dvld_q         <= 1'b0;
      gate_q         <= '0;
      en_q           <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        step_q[i]   <= 8'h00;
        target_q[i] <= 8'h00;
        level_q[i]  <= 8'h00;
      end
    end else begin
      state_q        <= state_d;
      v_q            <= v_d;
      tick_pending_q <= tick_pending_d;
      overrun_q      <= overrun_d;

      if (host_grant) begin
        data_q      <= bus.host_data_in;
        addr_q      <= bus.host_addr_in;
        dvld_q      <= 1'b1;
        last_host_q <= 1'b1;
      end else if (env_grant) begin
        data_q      <= {8'h00, cur_level};
        addr_q      <= VOL_BASE + {4'b0000, v_q};
        dvld_q      <= 1'b1;
        last_host_q <= 1'b0;
      end else begin
        dvld_q <= 1'b0;
      end

      if ((state_q == CALC) && en_q[v_q]) level_q[v_q] <= new_level;

      if (cfg_wr) begin
        if (!bus.host_addr_in[2]) begin
          gate_q[cfg_idx] <= bus.host_data_in[15];
          en_q[cfg_idx]   <= bus.host_data_in[14];
          step_q[cfg_idx] <= bus.host_data_in[7:0];
        end else begin
          target_q[cfg_idx] <= bus.host_data_in[7:0];
        end
      end
    end
  end

  assign bus.host_ready_out = host_ready;
  assign bus.data_out       = data_q;
  assign bus.addr_out       = addr_q;
  assign bus.data_valid_out = dvld_q;
  assign bus.busy_out       = busy;
  assign bus.overrun_out    = overrun_q;

endmodule
